unary_fft_decoder: RTL and testbench
====================================

// Module: unary_fft_decoder
// PURPOSE
//  Output end of the unary FFT datapath: samples the per-lane oReal/oImg bitstreams
//  from the FFT over a fixed window of 2**BITWIDTH enabled cycles and counts ones.
//  Produces one binary word per lane, real and imaginary.
//  Results are presented with a valid/ready handshake to downstream binary logic.
// PARAMETERS
//  BITWIDTH   8  log2 of window length; window = 2**BITWIDTH enabled samples
//  NUMINPUTS  2  lanes per component (matches FFT size)
//  OW         BITWIDTH+1  derived, per-lane result width (localparam)
// PORTS
//  iClk     in   1             clock, all logic on rising edge
//  iRstN    in   1             synchronous reset, active-low
//  iEn      in   1             sample enable; low = stall, no sample taken
//  iClr     in   1             synchronous clear (abort window)
//  iStart   in   1             begin new window (accepted only in IDLE)
//  iReal    in   NUMINPUTS     real bitstreams, bit k = lane k
//  iImg     in   NUMINPUTS     imaginary bitstreams
//  iReady   in   1             downstream accepts result
//  oValid   out  1             result registers valid
//  oBusy    out  1             high in ACC
//  oReal    out  NUMINPUTS*OW  lane k at [k*OW +: OW]
//  oImg     out  NUMINPUTS*OW  same packing
// BEHAVIOUR
//  Reset (iRstN=0 at edge): state IDLE, sample counter, accumulators, oReal, oImg,
//   oValid, oBusy all 0. Overrides every other input, including mid-window.
//  iClr=1 (iRstN=1): same effect as reset; priority over iStart/iEn/iReady.
//  States:
//   IDLE: iStart=1 -> ACC; sample counter and accumulators cleared.
//         Sampling starts the cycle after iStart.
//   ACC: each cycle with iEn=1, acc[k] += bit k of each component; counter++.
//        iEn=0 holds everything. iStart ignored.
//        On the enabled sample where counter==2**BITWIDTH-1, at that edge:
//        oReal/oImg <= final value (including the current bit), oValid<=1,
//        state -> HOLD.
//   HOLD: oValid=1; outputs stable. iStart ignored.
//         iReady=1 -> IDLE, oValid<=0; output data retained.
//  Latency: oValid rises 1 cycle after the last enabled sample is presented.
//   With no stalls, that is 2**BITWIDTH+1 cycles after the iStart cycle.
//  Accumulators are OW bits wide; max count 2**BITWIDTH, so they never wrap.
//   Sample counter is BITWIDTH bits and wraps to 0 at window end.
//  oValid deasserts only on handshake, clear or reset; data is not updated while
//   oValid=1.
//  iReady while oValid=0 has no effect. X on iReal/iImg is not sampled when iEn=0.
// CONFIGURATION
//  BIPOLAR_EN defined: each output = 2*ones - 2**BITWIDTH, OW-bit two's complement.
//   Range -2**BITWIDTH .. +2**BITWIDTH; +2**BITWIDTH saturates to 2**BITWIDTH-1.
//  BIPOLAR_EN undefined: each output = raw ones count, unsigned, 0 .. 2**BITWIDTH.
//  Affects only the final output mapping; counting and timing are identical.
// TESTING  (BITWIDTH=4, NUMINPUTS=2, window 16)
//  all lanes 1 for 16 cycles -> outputs 16 (unipolar) / 15 sat (BIPOLAR_EN);
//   oValid at cycle 17 after iStart.
//  Real lane0 alternating 1010.., lane1 zeros -> real0=8 / 0; real1=0 / -16 (0x10).
//  iEn low 5 cycles mid-window -> same values; oValid 5 cycles later.
//  iReady low 10 cycles in HOLD -> oValid and data held; iReady pulse -> IDLE;
//   iStart same cycle ignored.
//  iClr at sample 7 -> next cycle IDLE, oValid=0, outputs 0; restart gives correct result.
//  iRstN low mid-window and in HOLD -> all outputs 0 next cycle; iStart ignored in ACC.

Source files
------------

// File: rtl/unary_fft_decoder.sv
// unary_fft_decoder
//   Output stage of the unary FFT datapath. Counts ones on each lane's real and
//   imaginary bitstream over a window of 2**BITWIDTH enabled samples and presents
//   one binary word per lane through a valid/ready handshake.
//
//   Optional feature macro: BIPOLAR_EN
//     defined   : output = 2*ones - 2**BITWIDTH (two's complement, +2**BITWIDTH
//                 saturates to 2**BITWIDTH-1)
//     undefined : output = raw ones count (unsigned)
//
//   Ports
//     iClk    clock, rising edge
//     iRstN   synchronous reset, active-low
//     iEn     sample enable (low = stall)
//     iClr    synchronous clear, aborts any window
//     iStart  begin a new window (only honoured in IDLE)
//     iReal   real bitstreams, bit k = lane k
//     iImg    imaginary bitstreams, bit k = lane k
//     iReady  downstream accepts the result
//     oValid  result valid
//     oBusy   window in progress
//     oReal   lane k at [k*OW +: OW], OW = BITWIDTH+1
//     oImg    same packing as oReal
module unary_fft_decoder #(
    parameter int BITWIDTH  = 8,
    parameter int NUMINPUTS = 2
) (
    input  logic                                iClk,
    input  logic                                iRstN,
    input  logic                                iEn,
    input  logic                                iClr,
    input  logic                                iStart,
    input  logic [NUMINPUTS-1:0]                iReal,
    input  logic [NUMINPUTS-1:0]                iImg,
    input  logic                                iReady,
    output logic                                oValid,
    output logic                                oBusy,
    output logic [NUMINPUTS*(BITWIDTH+1)-1:0]   oReal,
    output logic [NUMINPUTS*(BITWIDTH+1)-1:0]   oImg
);

    localparam int OW = BITWIDTH + 1;
    localparam logic [BITWIDTH-1:0] CNT_MAX = {BITWIDTH{1'b1}};

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    state_e                      r_state;
    state_e                      w_state_next;
    logic [BITWIDTH-1:0]         r_cnt;
    logic [NUMINPUTS*OW-1:0]     r_acc_re;
    logic [NUMINPUTS*OW-1:0]     r_acc_im;
    logic [NUMINPUTS*OW-1:0]     r_real;
    logic [NUMINPUTS*OW-1:0]     r_img;
    logic                        r_valid;
    logic [NUMINPUTS*OW-1:0]     w_sum_re;
    logic [NUMINPUTS*OW-1:0]     w_sum_im;
    logic [NUMINPUTS*OW-1:0]     w_map_re;
    logic [NUMINPUTS*OW-1:0]     w_map_im;
    logic                        w_last;

    // Maps a ones count (0 .. 2**BITWIDTH) to the output encoding.
    function automatic logic [OW-1:0] f_map(input logic [OW-1:0] ones);
`ifdef BIPOLAR_EN
        logic [OW-1:0] full;
        logic [OW-1:0] sat;
        full = {1'b1, {BITWIDTH{1'b0}}};
        sat  = {1'b0, {BITWIDTH{1'b1}}};
        if (ones == full) begin
            f_map = sat;
        end else begin
            // 2*ones drops the top bit safely: ones < 2**BITWIDTH here.
            f_map = {ones[OW-2:0], 1'b0} - full;
        end
`else
        f_map = ones;
`endif
    endfunction

    // Running sums include the bit presented this cycle so the final edge
    // captures the complete count.
    always_comb begin
        w_sum_re = '0;
        w_sum_im = '0;
        w_map_re = '0;
        w_map_im = '0;
        for (int k = 0; k < NUMINPUTS; k++) begin
            w_sum_re[k*OW +: OW] = r_acc_re[k*OW +: OW] + {{(OW-1){1'b0}}, iReal[k]};
            w_sum_im[k*OW +: OW] = r_acc_im[k*OW +: OW] + {{(OW-1){1'b0}}, iImg[k]};
            w_map_re[k*OW +: OW] = f_map(w_sum_re[k*OW +: OW]);
            w_map_im[k*OW +: OW] = f_map(w_sum_im[k*OW +: OW]);
        end
    end

    assign w_last = iEn && (r_cnt == CNT_MAX);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (iStart) w_state_next = StAcc;
            StAcc:   if (w_last) w_state_next = StHold;
            StHold:  if (iReady) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
        if (iClr) begin
            w_state_next = StIdle;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstN || iClr) begin
            r_cnt    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_real   <= '0;
            r_img    <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (iStart) begin
                        r_cnt    <= '0;
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                    end
                end
                StAcc: begin
                    if (iEn) begin
                        // Counter wraps to 0 on the last sample.
                        r_cnt    <= r_cnt + BITWIDTH'(1);
                        r_acc_re <= w_sum_re;
                        r_acc_im <= w_sum_im;
                        if (w_last) begin
                            r_real  <= w_map_re;
                            r_img   <= w_map_im;
                            r_valid <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (iReady) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oValid = r_valid;
    assign oBusy  = (r_state == StAcc);
    assign oReal  = r_real;
    assign oImg   = r_img;

endmodule

// File: tb/tb_unary_fft_decoder.sv
module tb_unary_fft_decoder;

    localparam int BW  = 4;
    localparam int NI  = 2;
    localparam int OW  = BW + 1;
    localparam int WIN = 1 << BW;

    logic              iClk;
    logic              iRstN;
    logic              iEn;
    logic              iClr;
    logic              iStart;
    logic [NI-1:0]     iReal;
    logic [NI-1:0]     iImg;
    logic              iReady;
    logic              oValid;
    logic              oBusy;
    logic [NI*OW-1:0]  oReal;
    logic [NI*OW-1:0]  oImg;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard entries: {expected oReal, expected oImg}
    logic [2*NI*OW-1:0] exp_q[$];
    logic [NI*OW-1:0]   last_re;
    logic [NI*OW-1:0]   last_im;

    unary_fft_decoder #(
        .BITWIDTH (BW),
        .NUMINPUTS(NI)
    ) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iEn   (iEn),
        .iClr  (iClr),
        .iStart(iStart),
        .iReal (iReal),
        .iImg  (iImg),
        .iReady(iReady),
        .oValid(oValid),
        .oBusy (oBusy),
        .oReal (oReal),
        .oImg  (oImg)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [OW-1:0] model_map(input int ones);
        logic [OW-1:0] v;
`ifdef BIPOLAR_EN
        if (ones == WIN) v = OW'(WIN - 1);
        else             v = OW'(2 * ones - WIN);
`else
        v = OW'(ones);
`endif
        return v;
    endfunction

    // Runs one full window. stall_at < 0 means no stall.
    task automatic run_window(input logic [WIN-1:0] re0, input logic [WIN-1:0] re1,
                              input logic [WIN-1:0] im0, input logic [WIN-1:0] im1,
                              input int stall_at, input int stall_len,
                              input bit start_in_acc, input bit handshake);
        logic [NI*OW-1:0]   er;
        logic [NI*OW-1:0]   ei;
        logic [2*NI*OW-1:0] ent;
        er = {model_map($countones(re1)), model_map($countones(re0))};
        ei = {model_map($countones(im1)), model_map($countones(im0))};
        exp_q.push_back({er, ei});
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (i == stall_at) begin
                for (int j = 0; j < stall_len; j++) begin
                    iEn   = 1'b0;
                    iReal = 'x;
                    iImg  = 'x;
                    step();
                end
            end
            iEn    = 1'b1;
            iReal  = {re1[i], re0[i]};
            iImg   = {im1[i], im0[i]};
            iStart = start_in_acc;
            if (i == WIN - 1) begin
                n_cmp++;
                if (oValid !== 1'b0) begin
                    n_err++;
                    $display("FAIL early_valid: oValid=%b required 0", oValid);
                end
                n_cmp++;
                if (oBusy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_in_acc: oBusy=%b required 1", oBusy);
                end
            end
            step();
        end
        iEn    = 1'b0;
        iStart = 1'b0;
        iReal  = '0;
        iImg   = '0;
        n_cmp++;
        if (oValid !== 1'b1) begin
            n_err++;
            $display("FAIL valid_latency: oValid=%b required 1", oValid);
        end
        n_cmp++;
        if (oBusy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_in_hold: oBusy=%b required 0", oBusy);
        end
        ent     = exp_q.pop_front();
        last_re = ent[2*NI*OW-1 -: NI*OW];
        last_im = ent[NI*OW-1:0];
        n_cmp++;
        if (oReal !== last_re) begin
            n_err++;
            $display("FAIL real_data: oReal=%h required %h", oReal, last_re);
        end
        n_cmp++;
        if (oImg !== last_im) begin
            n_err++;
            $display("FAIL img_data: oImg=%h required %h", oImg, last_im);
        end
        if (handshake) begin
            iReady = 1'b1;
            step();
            iReady = 1'b0;
            n_cmp++;
            if (oValid !== 1'b0) begin
                n_err++;
                $display("FAIL handshake: oValid=%b required 0", oValid);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        if ({oValid, oBusy, oReal, oImg} !== '0) begin
            n_err++;
            $display("FAIL %s: valid=%b busy=%b real=%h img=%h required all 0",
                     tag, oValid, oBusy, oReal, oImg);
        end
    endtask

    task automatic test_reset();
        iRstN = 1'b0;
        step();
        step();
        check_zero("reset_state");
        iRstN = 1'b1;
        step();
    endtask

    task automatic test_all_ones();
        run_window('1, '1, '1, '1, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_alternating();
        run_window(16'hAAAA, 16'h0000, 16'h0F0F, 16'h0001, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        logic [WIN-1:0] p0, p1, p2, p3;
        p0 = WIN'($urandom);
        p1 = WIN'($urandom);
        p2 = WIN'($urandom);
        p3 = WIN'($urandom);
        run_window(p0, p1, p2, p3, 6, 5, 1'b0, 1'b1);
    endtask

    task automatic test_start_in_acc();
        run_window(16'h1234, 16'hFFF0, 16'h8001, 16'h7FFE, -1, 0, 1'b1, 1'b1);
    endtask

    task automatic test_hold();
        run_window(16'hC3C3, 16'h0101, 16'hFFFF, 16'h00F0, -1, 0, 1'b0, 1'b0);
        iReady = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if (oValid !== 1'b1 || oReal !== last_re || oImg !== last_im) begin
                n_err++;
                $display("FAIL hold_stable: valid=%b real=%h img=%h required 1 %h %h",
                         oValid, oReal, oImg, last_re, last_im);
            end
        end
        iReady = 1'b1;
        iStart = 1'b1;
        step();
        iReady = 1'b0;
        iStart = 1'b0;
        n_cmp++;
        if (oValid !== 1'b0 || oBusy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_exit: valid=%b busy=%b required 0 0", oValid, oBusy);
        end
        n_cmp++;
        if (oReal !== last_re || oImg !== last_im) begin
            n_err++;
            $display("FAIL data_retained: real=%h img=%h required %h %h",
                     oReal, oImg, last_re, last_im);
        end
        step();
        n_cmp++;
        if (oBusy !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_hold: oBusy=%b required 0", oBusy);
        end
    endtask

    task automatic test_clear();
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        for (int i = 0; i < 7; i++) begin
            iEn   = 1'b1;
            iReal = '1;
            iImg  = '1;
            step();
        end
        iClr = 1'b1;
        step();
        iClr = 1'b0;
        iEn  = 1'b0;
        check_zero("clear_mid");
        run_window(16'h00FF, 16'h5555, 16'h0003, 16'hF00F, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_rst_mid();
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iEn   = 1'b1;
            iReal = '1;
            iImg  = '1;
            step();
        end
        iRstN  = 1'b0;
        iStart = 1'b1;
        step();
        iRstN  = 1'b1;
        iStart = 1'b0;
        iEn    = 1'b0;
        check_zero("reset_mid_window");
    endtask

    task automatic test_rst_hold();
        run_window(16'hFFFF, 16'h8000, 16'h0000, 16'h1111, -1, 0, 1'b0, 1'b0);
        iRstN = 1'b0;
        step();
        iRstN = 1'b1;
        check_zero("reset_in_hold");
    endtask

    initial begin
        iRstN  = 1'b1;
        iEn    = 1'b0;
        iClr   = 1'b0;
        iStart = 1'b0;
        iReal  = '0;
        iImg   = '0;
        iReady = 1'b0;
        test_reset();
        test_all_ones();
        test_alternating();
        test_stall();
        test_start_in_acc();
        test_hold();
        test_clear();
        test_rst_mid();
        test_rst_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
